ed_seq: RTL and testbench
=========================

Name: ed_seq

Overview:
- Multi-channel edge sequencer for the experiment-control timing path; drives one output bit per channel from the shared signed time counter.
- Each channel fires when count >= x + dx*outer_count, where outer_count is the outer-loop iteration index.
- The threshold is tracked incrementally per channel (add dx on each outer step), so no multiplier is needed.
- Adds runtime per-channel configuration, registered outputs, and a per-channel level/pulse mode with programmable pulse width.

Parameters:
IN_BITS, 32, width of count, x, dx and threshold (signed two's complement)
N_CH, 8, number of output channels
CH_BITS, 3, width of channel index; must satisfy 2^CH_BITS >= N_CH
W_BITS, 16, width of pulse-width field

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  global enable; 0 forces all outputs low
count  input  IN_BITS  signed time counter, sampled every cycle
outer_step  input  1  one-cycle strobe: outer_count increments
outer_clear  input  1  one-cycle strobe: outer_count returns to 0
cfg_we  input  1  configuration write strobe
cfg_ch  input  CH_BITS  channel addressed by cfg_we
cfg_x  input  IN_BITS  signed base offset x
cfg_dx  input  IN_BITS  signed per-iteration increment dx
cfg_mode  input  1  0 = level mode, 1 = pulse mode
cfg_width  input  W_BITS  pulse length in cycles (pulse mode only)
out  output  N_CH  registered channel outputs
fired  output  N_CH  sticky per-channel flag: channel has fired since last outer_step/outer_clear

Behaviour:
- Reset (async, rst_n=0): all x, dx, thr, mode, width registers = 0. All pulse counters = 0. All armed = 1. out = 0, fired = 0.
- Per-channel state: x, dx, thr (current threshold), mode, width, armed, pulse counter.
- Threshold update, priority highest first:
  - cfg_we addressed to the channel: x<=cfg_x, dx<=cfg_dx, thr<=cfg_x, mode and width loaded, armed<=1, pulse counter<=0.
  - outer_clear: thr<=x, armed<=1, fired<=0.
  - outer_step: thr<=thr+dx, armed<=1, fired<=0.
  - Simultaneous outer_clear and outer_step: clear wins.
  - cfg_we to channel k: channel k loads config; all other channels still process clear/step normally.
- Arithmetic: thr+dx wraps modulo 2^IN_BITS. No saturation and no overflow flag. The comparison count >= thr is signed.
- Hit: hit[i] = enable & (count >= thr[i]), using thr as registered at the start of the cycle.
- Level mode (mode=0):
  - out[i] <= hit[i]; one cycle latency from count to out.
  - fired[i] set on any hit.
- Pulse mode (mode=1):
  - When hit[i] & armed[i]: out[i]<=1, pulse counter<=max(width,1)-1, armed<=0, fired<=1.
  - While the pulse counter is nonzero, out stays 1 and the counter decrements each cycle. Out falls the cycle after the counter reaches 0.
  - Pulse length is exactly max(width,1) cycles; width=0 is treated as 1.
  - A channel fires at most once per outer iteration; rearm only via outer_step, outer_clear or cfg_we.
  - outer_step during an active pulse: the pulse completes its full length, and the new iteration may fire only after the pulse ends.
- enable=0:
  - out <= 0 next cycle; active pulses are aborted (counter<=0).
  - armed and fired retain their values; thresholds continue to track outer_step/outer_clear.
- cfg_ch >= N_CH: the write is ignored.
- Reset mid-pulse: out drops asynchronously; all state returns to reset values.

Test Plan:
1. Level, 1 iteration: ch0 x=100, dx=0, mode 0, enable=1, count ramps 95..105 -> out[0] first high the cycle after count=100, stays high; fired[0]=1.
2. Outer stepping: ch2 x=-50, dx=20, level mode; outer_step x3 -> fire points at count -50, -30, -10, 10; after outer_clear the fire point returns to -50.
3. Pulse: ch5 x=10, width=4, mode 1, count ramps 0..40 -> out[5] high exactly 4 cycles starting the cycle after count=10, no refire; outer_step then ramp again -> one more 4-cycle pulse; width=0 -> 1-cycle pulse.
4. Simultaneous events: cfg_we to ch1 in the same cycle as outer_step with thr1 and others nonzero -> ch1 thr=cfg_x, other channels thr+=dx; outer_clear+outer_step together -> thr=x.
5. Wrap/sign: x=0x7FFFFFF0, dx=0x20, one outer_step -> thr=0x80000010 (negative) and the channel fires for count=-2147483632; cfg_ch=9 with N_CH=8 -> no state change.
6. Enable/reset: drop enable mid-pulse -> out low next cycle, fired retained; assert rst_n=0 mid-pulse -> out=0 immediately, all registers zero after release.

Source files
------------

// File: rtl/ed_seq.sv
// ed_seq: multi-channel edge sequencer.
// Each channel compares the shared signed time counter against a threshold
// that starts at x and advances by dx on every outer-loop step. Channels run
// in level mode (out follows the hit) or pulse mode (one fixed-width pulse per
// outer iteration). All outputs are registered.
module ed_seq #(
    parameter int IN_BITS = 32,
    parameter int N_CH    = 8,
    parameter int CH_BITS = 3,
    parameter int W_BITS  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [IN_BITS-1:0] count,
    input  logic               outer_step,
    input  logic               outer_clear,
    input  logic               cfg_we,
    input  logic [CH_BITS-1:0] cfg_ch,
    input  logic [IN_BITS-1:0] cfg_x,
    input  logic [IN_BITS-1:0] cfg_dx,
    input  logic               cfg_mode,
    input  logic [W_BITS-1:0]  cfg_width,
    output logic [N_CH-1:0]    out,
    output logic [N_CH-1:0]    fired
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [IN_BITS-1:0] x_q, x_d, dx_q, dx_d, thr_q, thr_d;
        logic [W_BITS-1:0]  width_q, width_d, pcnt_q, pcnt_d;
        logic               mode_q, mode_d;
        logic               armed_q, armed_d;
        logic               out_q, out_d;
        logic               fired_q, fired_d;
        logic               wr, hit;

        // Indices at or above N_CH never match any channel, so such writes drop.
        assign wr  = cfg_we && (cfg_ch == CH_BITS'(i));
        assign hit = enable && ($signed(count) >= $signed(thr_q));

        // Next state: output/pulse behaviour first, then config and
        // outer-loop events override threshold, arming and the fired flag.
        always_comb begin
            x_d     = x_q;
            dx_d    = dx_q;
            thr_d   = thr_q;
            mode_d  = mode_q;
            width_d = width_q;
            armed_d = armed_q;
            pcnt_d  = pcnt_q;
            out_d   = out_q;
            fired_d = fired_q;

            if (!enable) begin
                // Abort any pulse; armed/fired are left alone.
                out_d  = 1'b0;
                pcnt_d = '0;
            end else if (!mode_q) begin
                out_d = hit;
                if (hit) fired_d = 1'b1;
            end else if (out_q) begin
                // Pulse in progress: out stays high until the counter has
                // run down, and no new fire is allowed on the falling edge.
                if (pcnt_q != '0) pcnt_d = pcnt_q - W_BITS'(1);
                else              out_d  = 1'b0;
            end else if (hit && armed_q) begin
                out_d   = 1'b1;
                pcnt_d  = (width_q == '0) ? '0 : width_q - W_BITS'(1);
                armed_d = 1'b0;
                fired_d = 1'b1;
            end

            if (wr) begin
                x_d     = cfg_x;
                dx_d    = cfg_dx;
                thr_d   = cfg_x;
                mode_d  = cfg_mode;
                width_d = cfg_width;
                armed_d = 1'b1;
                pcnt_d  = '0;
                out_d   = 1'b0;
            end else if (outer_clear) begin
                thr_d   = x_q;
                armed_d = 1'b1;
                fired_d = 1'b0;
            end else if (outer_step) begin
                // Wraps modulo 2^IN_BITS by design.
                thr_d   = thr_q + dx_q;
                armed_d = 1'b1;
                fired_d = 1'b0;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q     <= '0;
                dx_q    <= '0;
                thr_q   <= '0;
                mode_q  <= 1'b0;
                width_q <= '0;
                armed_q <= 1'b1;
                pcnt_q  <= '0;
                out_q   <= 1'b0;
                fired_q <= 1'b0;
            end else begin
                x_q     <= x_d;
                dx_q    <= dx_d;
                thr_q   <= thr_d;
                mode_q  <= mode_d;
                width_q <= width_d;
                armed_q <= armed_d;
                pcnt_q  <= pcnt_d;
                out_q   <= out_d;
                fired_q <= fired_d;
            end
        end

        assign out[i]   = out_q;
        assign fired[i] = fired_q;
    end

endmodule

// File: tb/tb_ed_seq.sv
// Bench for ed_seq: table of per-cycle stimulus rows with expected
// out/fired masks, checked through a scoreboard queue one cycle later,
// plus a hand-written asynchronous reset sequence.
module tb_ed_seq;

    localparam int IN_BITS = 32;
    localparam int N_CH    = 8;
    localparam int CH_BITS = 4;
    localparam int W_BITS  = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [IN_BITS-1:0] count;
    logic               outer_step, outer_clear;
    logic               cfg_we;
    logic [CH_BITS-1:0] cfg_ch;
    logic [IN_BITS-1:0] cfg_x, cfg_dx;
    logic               cfg_mode;
    logic [W_BITS-1:0]  cfg_width;
    logic [N_CH-1:0]    out, fired;

    ed_seq #(.IN_BITS(IN_BITS), .N_CH(N_CH), .CH_BITS(CH_BITS), .W_BITS(W_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .count(count),
        .outer_step(outer_step), .outer_clear(outer_clear),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_x(cfg_x), .cfg_dx(cfg_dx),
        .cfg_mode(cfg_mode), .cfg_width(cfg_width),
        .out(out), .fired(fired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               en, stp, clr, we, mode;
        logic [IN_BITS-1:0] cnt, x, dx;
        logic [CH_BITS-1:0] ch;
        logic [W_BITS-1:0]  width;
        logic [N_CH-1:0]    care, eo, ef;
    } vec_t;

    typedef struct {
        int              idx;
        logic [N_CH-1:0] care, eo, ef;
    } exp_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Plain cycle, checking one channel.
    function automatic vec_t V(bit en, int cnt, bit stp, bit clr, int ch, bit eo, bit ef);
        vec_t r = '0;
        r.en = en; r.cnt = cnt; r.stp = stp; r.clr = clr;
        r.care[ch] = 1'b1; r.eo[ch] = eo; r.ef[ch] = ef;
        return r;
    endfunction

    // Plain cycle, checking all channels.
    function automatic vec_t F(bit en, int cnt, logic [N_CH-1:0] eo, logic [N_CH-1:0] ef);
        vec_t r = '0;
        r.en = en; r.cnt = cnt; r.care = '1; r.eo = eo; r.ef = ef;
        return r;
    endfunction

    // Config write cycle (enable low), optionally with an outer step.
    function automatic vec_t C(int ch, int x, int dx, bit mode, int width, bit stp = 1'b0);
        vec_t r = '0;
        r.we = 1'b1; r.ch = CH_BITS'(ch); r.x = x; r.dx = dx;
        r.mode = mode; r.width = W_BITS'(width); r.stp = stp;
        return r;
    endfunction

    task automatic check(input string what, input int idx, input logic [N_CH-1:0] got,
                         input logic [N_CH-1:0] want, input logic [N_CH-1:0] care);
        n_tests++;
        if ((got & care) !== (want & care)) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b want %b (care %b)", what, idx, got, want, care);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        enable = v.en; count = v.cnt; outer_step = v.stp; outer_clear = v.clr;
        cfg_we = v.we; cfg_ch = v.ch; cfg_x = v.x; cfg_dx = v.dx;
        cfg_mode = v.mode; cfg_width = v.width;
        if (v.care != '0) sb.push_back('{idx, v.care, v.eo, v.ef});
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out", e.idx, out, e.eo, e.care);
            check("fired", e.idx, fired, e.ef, e.care);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Level mode, single iteration on ch0.
        tbl_a.push_back(C(0, 100, 0, 0, 0));
        for (int c = 95; c <= 105; c++) tbl_a.push_back(V(1, c, 0, 0, 0, c >= 100, c >= 100));

        // Outer stepping on ch2: fire points -50, -30, -10, 10, then clear.
        tbl_a.push_back(C(2, -50, 20, 0, 0));
        tbl_a.push_back(V(1, -1000, 0, 1, 2, 0, 0));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tbl_a.push_back(V(1, -1000, 1, 0, 2, 0, 0));
            tbl_a.push_back(V(1, -50 + 20 * k - 1, 0, 0, 2, 0, 0));
            tbl_a.push_back(V(1, -50 + 20 * k, 0, 0, 2, 1, 1));
        end
        tbl_a.push_back(V(1, -1000, 0, 1, 2, 0, 0));
        tbl_a.push_back(V(1, -51, 0, 0, 2, 0, 0));
        tbl_a.push_back(V(1, -50, 0, 0, 2, 1, 1));

        // Pulse mode ch5, width 4: one pulse per ramp, step rearms.
        tbl_a.push_back(C(5, 10, 0, 1, 4));
        tbl_a.push_back(V(1, -1000, 0, 1, 5, 0, 0));
        for (int rep = 0; rep < 2; rep++) begin
            if (rep > 0) tbl_a.push_back(V(1, 40, 1, 0, 5, 0, 0));
            for (int c = 0; c <= 40; c++)
                tbl_a.push_back(V(1, c, 0, 0, 5, (c >= 10) && (c <= 13), c >= 10));
        end
        // Width 0 behaves as a 1-cycle pulse.
        tbl_a.push_back(C(5, 10, 0, 1, 0));
        tbl_a.push_back(V(1, -1000, 0, 1, 5, 0, 0));
        for (int c = 8; c <= 14; c++) tbl_a.push_back(V(1, c, 0, 0, 5, c == 10, c >= 10));
        // Step mid-pulse: pulse runs its full 4 cycles, refire only afterwards.
        tbl_a.push_back(C(5, 10, 0, 1, 4));
        tbl_a.push_back(V(1, -1000, 0, 1, 5, 0, 0));
        tbl_a.push_back(V(1, 10, 0, 0, 5, 1, 1));
        tbl_a.push_back(V(1, 20, 1, 0, 5, 1, 0));
        tbl_a.push_back(V(1, 20, 0, 0, 5, 1, 0));
        tbl_a.push_back(V(1, 20, 0, 0, 5, 1, 0));
        tbl_a.push_back(V(1, 20, 0, 0, 5, 0, 0));
        tbl_a.push_back(V(1, 20, 0, 0, 5, 1, 1));

        // Simultaneous events: cfg to ch1 with step; ch3 keeps stepping.
        tbl_a.push_back(C(3, 0, 100, 0, 0));
        tbl_a.push_back(C(1, 500, 7, 0, 0));
        tbl_a.push_back(V(1, -1000, 0, 1, 3, 0, 0));
        tbl_a.push_back(V(1, -1000, 1, 0, 3, 0, 0));
        tbl_a.push_back(C(1, -5, 0, 0, 0, 1));
        tbl_a.push_back(V(1, 199, 0, 0, 3, 0, 0));
        tbl_a.push_back(V(1, 200, 0, 0, 3, 1, 1));
        tbl_a.push_back(V(1, -6, 0, 0, 1, 0, 1));
        tbl_a.push_back(V(1, -5, 0, 0, 1, 1, 1));
        // Clear and step together: clear wins, ch3 threshold back to 0.
        tbl_a.push_back(V(1, -1000, 1, 1, 3, 0, 0));
        tbl_a.push_back(V(1, -1, 0, 0, 3, 0, 0));
        tbl_a.push_back(V(1, 0, 0, 0, 3, 1, 1));

        // Wrap and signed compare on ch4.
        tbl_a.push_back(C(4, 32'h7FFF_FFF0, 32'h20, 0, 0));
        tbl_a.push_back(V(1, -1000, 0, 1, 4, 0, 0));
        tbl_a.push_back(V(1, 32'h7FFF_FFEF, 0, 0, 4, 0, 0));
        tbl_a.push_back(V(1, 32'h7FFF_FFF0, 0, 0, 4, 1, 1));
        tbl_a.push_back(V(1, -1000, 1, 0, 4, 0, 0));
        tbl_a.push_back(V(1, -2147483633, 0, 0, 4, 0, 0));
        tbl_a.push_back(V(1, -2147483632, 0, 0, 4, 1, 1));
        tbl_a.push_back(V(1, 0, 0, 0, 4, 1, 1));
        // Out-of-range channel write must not touch ch4 or ch1.
        tbl_a.push_back(C(9, 1000, 0, 1, 4));
        tbl_a.push_back(V(1, -2147483633, 0, 0, 4, 0, 1));
        tbl_a.push_back(V(1, -2147483632, 0, 0, 4, 1, 1));
        tbl_a.push_back(V(1, -6, 0, 0, 1, 0, 1));
        tbl_a.push_back(V(1, -5, 0, 0, 1, 1, 1));

        // Enable drop mid-pulse, then start another pulse for the reset test.
        tbl_a.push_back(C(5, 10, 0, 1, 4));
        tbl_a.push_back(V(1, -1000, 0, 1, 5, 0, 0));
        tbl_a.push_back(V(1, 10, 0, 0, 5, 1, 1));
        tbl_a.push_back(V(1, 11, 0, 0, 5, 1, 1));
        tbl_a.push_back(V(0, 12, 0, 0, 5, 0, 1));
        tbl_a.push_back(V(1, 12, 0, 0, 5, 0, 1));
        tbl_a.push_back(V(1, -1000, 0, 1, 5, 0, 0));
        tbl_a.push_back(V(1, 10, 0, 0, 5, 1, 1));

        // After reset every channel is level mode with threshold 0.
        tbl_b.push_back(F(1, -1, '0, '0));
        tbl_b.push_back(F(1, 0, '1, '1));

        // Power-on reset.
        rst_n = 1'b0; enable = 1'b0; count = '0; outer_step = 1'b0; outer_clear = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_x = '0; cfg_dx = '0; cfg_mode = 1'b0; cfg_width = '0;
        #12;
        check("reset_out", -1, out, '0, '1);
        check("reset_fired", -1, fired, '0, '1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl_a[i]) apply(tbl_a[i], i);

        // Reset mid-pulse: out must drop without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_rst_out", -2, out, '0, '1);
        check("async_rst_fired", -2, fired, '0, '1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl_b[i]) apply(tbl_b[i], 1000 + i);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
